draw_text_overlay: RTL

- Parametrised text-window overlay for the VGA pipeline.
- Generalises the fixed-position character drawer with:
  - runtime position, colour and enable, shadow-latched once per frame;
  - integer glyph scaling (1x/2x/4x…);
  - configurable font and grid geometry;
  - configurable external text-buffer/font-ROM latency.
- Sits inline between two vga_if pipeline stages. Drives the external char buffer + font ROM chain and paints glyph pixels over rgb_i.

---
 rtl/draw_text_overlay_if.sv | 12 +
 rtl/draw_text_overlay.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/draw_text_overlay_if.sv
// vga_if: VGA timing bundle passed between pipeline stages of the overlay chain.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk);
endinterface

// File: rtl/draw_text_overlay.sv
// draw_text_overlay: scaled text-window overlay with a per-frame shadowed position, colour and enable.
// Optional macro TEXT_BG_EN adds a shadowed bg_color port that fills glyph-off pixels inside the window.
module draw_text_overlay #(
    parameter int CHAR_COLS  = 16,
    parameter int CHAR_ROWS  = 16,
    parameter int FONT_W     = 8,
    parameter int FONT_H     = 16,
    parameter int SCALE_LOG2 = 0,
    parameter int ROM_LAT    = 2,
    parameter int RGB_B      = 12
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [10:0]                                  pos_x,
    input  logic [10:0]                                  pos_y,
    input  logic [RGB_B-1:0]                             font_color,
`ifdef TEXT_BG_EN
    input  logic [RGB_B-1:0]                             bg_color,
`endif
    input  logic                                         enable,
    output logic [$clog2(CHAR_ROWS)+$clog2(CHAR_COLS)-1:0] char_addr,
    output logic [$clog2(FONT_H)-1:0]                    char_line,
    input  logic [FONT_W-1:0]                            char_pixels,
    vga_if.in                                            vga_in,
    input  logic [RGB_B-1:0]                             rgb_i,
    vga_if.out                                           vga_out,
    output logic [RGB_B-1:0]                             rgb_o
);
    localparam int COL_W = $clog2(CHAR_COLS);
    localparam int ROW_W = $clog2(CHAR_ROWS);
    localparam int FW_W  = $clog2(FONT_W);
    localparam int FH_W  = $clog2(FONT_H);
    localparam int DEPTH = ROM_LAT + 1;
    localparam logic [12:0] BOX_W = 13'(CHAR_COLS * FONT_W << SCALE_LOG2);
    localparam logic [12:0] BOX_H = 13'(CHAR_ROWS * FONT_H << SCALE_LOG2);

    typedef struct packed {
        logic             in_box;
        logic [FW_W-1:0]  bit_idx;
        logic [RGB_B-1:0] color;
`ifdef TEXT_BG_EN
        logic [RGB_B-1:0] bg;
`endif
        logic [RGB_B-1:0] rgb;
        logic [10:0]      hcount;
        logic             hsync;
        logic             hblnk;
        logic [10:0]      vcount;
        logic             vsync;
        logic             vblnk;
    } stage_t;

    logic [10:0]      act_x_reg;
    logic [10:0]      act_y_reg;
    logic [RGB_B-1:0] act_color_reg;
`ifdef TEXT_BG_EN
    logic [RGB_B-1:0] act_bg_reg;
`endif
    logic             act_en_reg;
    logic             vblnk_prev_reg;

    logic [11:0]      rel_x;
    logic [11:0]      rel_y;
    logic [10:0]      sx;
    logic [10:0]      sy;
    logic             in_box;
    stage_t           stage0;
    stage_t           pipe_reg [DEPTH];
    stage_t           tail;
    logic             glyph_on;

    // The extra top bit makes a window start right of the beam show up as a negative offset.
    assign rel_x = {1'b0, vga_in.hcount} - {1'b0, act_x_reg};
    assign rel_y = {1'b0, vga_in.vcount} - {1'b0, act_y_reg};
    assign sx    = rel_x[10:0] >> SCALE_LOG2;
    assign sy    = rel_y[10:0] >> SCALE_LOG2;

    assign in_box = act_en_reg
                  & ~rel_x[11] & ({2'b00, rel_x[10:0]} < BOX_W)
                  & ~rel_y[11] & ({2'b00, rel_y[10:0]} < BOX_H)
                  & ~vga_in.hblnk & ~vga_in.vblnk;

    always_comb begin
        stage0         = '0;
        stage0.in_box  = in_box;
        stage0.bit_idx = FW_W'(sx);
        stage0.color   = act_color_reg;
`ifdef TEXT_BG_EN
        stage0.bg      = act_bg_reg;
`endif
        stage0.rgb     = rgb_i;
        stage0.hcount  = vga_in.hcount;
        stage0.hsync   = vga_in.hsync;
        stage0.hblnk   = vga_in.hblnk;
        stage0.vcount  = vga_in.vcount;
        stage0.vsync   = vga_in.vsync;
        stage0.vblnk   = vga_in.vblnk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev_reg <= 1'b0;
            act_x_reg      <= '0;
            act_y_reg      <= '0;
            act_color_reg  <= '0;
`ifdef TEXT_BG_EN
            act_bg_reg     <= '0;
`endif
            act_en_reg     <= 1'b0;
            char_addr      <= '0;
            char_line      <= '0;
        end else begin
            vblnk_prev_reg <= vga_in.vblnk;
            if (vga_in.vblnk && !vblnk_prev_reg) begin
                act_x_reg     <= pos_x;
                act_y_reg     <= pos_y;
                act_color_reg <= font_color;
`ifdef TEXT_BG_EN
                act_bg_reg    <= bg_color;
`endif
                act_en_reg    <= enable;
            end
            char_addr <= {ROW_W'(sy >> FH_W), COL_W'(sx >> FW_W)};
            char_line <= FH_W'(sy);
        end
    end

    // Side-band data rides alongside the ROM fetch so it meets char_pixels in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) pipe_reg[gi] <= '0;
                    else     pipe_reg[gi] <= stage0;
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) pipe_reg[gi] <= '0;
                    else     pipe_reg[gi] <= pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign tail     = pipe_reg[DEPTH-1];
    assign glyph_on = char_pixels[tail.bit_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_o          <= '0;
            vga_out.hcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
        end else begin
            if (tail.in_box && glyph_on)
                rgb_o <= tail.color;
`ifdef TEXT_BG_EN
            else if (tail.in_box)
                rgb_o <= tail.bg;
`endif
            else
                rgb_o <= tail.rgb;
            vga_out.hcount <= tail.hcount;
            vga_out.hsync  <= tail.hsync;
            vga_out.hblnk  <= tail.hblnk;
            vga_out.vcount <= tail.vcount;
            vga_out.vsync  <= tail.vsync;
            vga_out.vblnk  <= tail.vblnk;
        end
    end
endmodule
